// File: rtl/mac_accum_stage.sv
// Signed MAC stage: LEN products summed, rescaled by FRAC, valid/ready out.
// Optional clipping to DATA_W when MAC_SATURATE_EN is defined.
module mac_accum_stage #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LEN    = 8,
  parameter int FRAC   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] in_weight,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic        [DATA_W-1:0] out_data,
  output logic                     out_sat,
  input  logic                     out_ready
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FLUSH  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [PW-1:0]    prod;
  logic                    prod_v;
  logic                    prod_last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [DATA_W-1:0]       res_data;
  logic                    res_sat;
  logic                    accept;
  logic                    take_last;
  logic                    finish;

  assign in_ready  = (state == ACCUM) && !rst;
  assign accept    = in_valid && in_ready;
  assign take_last = accept && (cnt == CNT_LAST);
  assign finish    = prod_v && prod_last;
  assign acc_sum   = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

`ifdef MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] R_MAX =
    ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] R_MIN = -R_MAX - 1;

  logic signed [ACC_W-1:0] r;
  assign r = acc_sum >>> FRAC;

  // Clip the rescaled sum into the signed output range
  always_comb begin
    res_sat  = 1'b0;
    res_data = r[DATA_W-1:0];
    if (r > R_MAX) begin
      res_sat  = 1'b1;
      res_data = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (r < R_MIN) begin
      res_sat  = 1'b1;
      res_data = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  // Wrap: keep the low DATA_W bits of the rescaled sum
  always_comb begin
    res_sat  = 1'b0;
    res_data = DATA_W'(acc_sum >>> FRAC);
  end
`endif

  // Stage 1: register the product of each accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod      <= '0;
      prod_v    <= 1'b0;
      prod_last <= 1'b0;
      cnt       <= '0;
    end else begin
      prod_v    <= accept;
      prod_last <= take_last;
      if (accept) begin
        prod <= in_data * in_weight;
        cnt  <= take_last ? '0 : cnt + 1'b1;
      end
    end
  end

  // Stage 2: accumulate, and on the last product emit the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef MAC_SATURATE_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      if (finish) begin
        acc       <= '0;
        out_valid <= 1'b1;
        out_data  <= res_data;
`ifdef MAC_SATURATE_EN
        out_sat   <= res_sat;
`endif
      end else begin
        if (prod_v)
          acc <= acc_sum;
        if (out_valid && out_ready)
          out_valid <= 1'b0;
      end
    end
  end

`ifndef MAC_SATURATE_EN
  assign out_sat = res_sat;
`endif

  // Control: accumulate, wait for the last product, hold the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      unique case (state)
        ACCUM:   if (take_last) state <= FLUSH;
        FLUSH:   if (finish) state <= OUTPUT;
        OUTPUT:  if (out_valid && out_ready) state <= ACCUM;
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Directed bench for mac_accum_stage.
// Expected values are hand-computed Q8 dot products.
module tb_mac_accum_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] in_weight = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_accum_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed n samples; returns just after the edge of the last accept.
  task automatic feed(input logic [15:0] d,
                      input logic [15:0] w,
                      input int n,
                      input bit bubbles);
    int got = 0;
    int guard = 0;
    bit fire;
    in_data   = d;
    in_weight = w;
    while (got < n && guard < 200) begin
      in_valid = bubbles ? ~in_valid : 1'b1;
      fire = in_valid && in_ready;
      tick();
      if (fire) got++;
      guard++;
    end
    in_valid = 1'b0;
    check("feed_count", got, n);
  endtask

  // After the last accept edge E0: check FLUSH then the result at E0+1.
  task automatic expect_result(input string tag,
                               input logic [15:0] d,
                               input logic s);
    check({tag, "_flush_rdy"}, in_ready, 0);
    check({tag, "_flush_vld"}, out_valid, 0);
    tick();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_sat"}, out_sat, s);
    check({tag, "_out_rdy"}, in_ready, 0);
  endtask

  task automatic expect_done(input string tag);
    tick();
    check({tag, "_done_vld"}, out_valid, 0);
    check({tag, "_done_rdy"}, in_ready, 1);
  endtask

  initial begin
    #2;
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);
    check("rst_rdy", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_rdy", in_ready, 1);

    // Nominal
    feed(16'h0100, 16'h0200, 8, 1'b0);
    expect_result("nom", 16'h1000, 1'b0);
    expect_done("nom");

    // Negative
    feed(16'hFF00, 16'h0100, 8, 1'b0);
    expect_result("neg", 16'hF800, 1'b0);
    expect_done("neg");

    // Overflow
    feed(16'h7FFF, 16'h7FFF, 8, 1'b0);
`ifdef MAC_SATURATE_EN
    expect_result("ovf", 16'h7FFF, 1'b1);
`else
    expect_result("ovf", 16'hF800, 1'b0);
`endif
    expect_done("ovf");

    // Backpressure, with ignored samples while holding
    out_ready = 1'b0;
    feed(16'h0100, 16'h0200, 8, 1'b0);
    expect_result("bp", 16'h1000, 1'b0);
    in_data   = 16'h7FFF;
    in_weight = 16'h7FFF;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_data", out_data, 16'h1000);
      check("bp_hold_rdy", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_done("bp");
    feed(16'h0100, 16'h0200, 8, 1'b0);
    expect_result("bp2", 16'h1000, 1'b0);
    expect_done("bp2");

    // Bubbles
    feed(16'h0100, 16'h0200, 8, 1'b1);
    expect_result("bub", 16'h1000, 1'b0);
    expect_done("bub");

    // Reset mid-operation
    feed(16'h0100, 16'h0200, 3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_vld", out_valid, 0);
    check("mrst_rdy", in_ready, 0);
    tick();
    check("mrst_hold_rdy", in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_rel_rdy", in_ready, 1);
    feed(16'h0100, 16'h0100, 8, 1'b0);
    expect_result("mrst", 16'h0800, 1'b0);
    expect_done("mrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
